// File: rtl/bin2bcd_pkg.sv
// Shared types and default constants for the binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned DEF_WIDTH     = 14;
    localparam int unsigned DEF_DIGITS    = 4;
    localparam int unsigned DEF_MAX_VALUE = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a client and the bin2bcd converter.
interface bin2bcd_if
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    bcd_t             unidades_output;
    bcd_t             decenas_output;
    bcd_t             centenas_output;
    bcd_t             milesimas_output;

    modport master (
        output start, bin_in,
        input  busy, done, overflow,
        input  unidades_output, decenas_output, centenas_output, milesimas_output
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow,
        output unidades_output, decenas_output, centenas_output, milesimas_output
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  bcd_t i_digit,
    output bcd_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/module_bin2bcd.sv
// Iterative binary-to-BCD converter (one bit per clock) with saturation above MAX_VALUE.
module module_bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DIGITS    = DEF_DIGITS,
    parameter int unsigned MAX_VALUE = DEF_MAX_VALUE
) (
    input  logic     clk,
    input  logic     rst_n,
    bin2bcd_if.slave bus_if
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           r_state, w_state_next;
    logic [SR_W-1:0]  r_sr, w_sr_next, w_sr_adj;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_pend, w_pend_next;
    logic             r_done, w_done_next;
    logic             r_ovf, w_ovf_next;
    bcd_t             r_dig [DIGITS];
    bcd_t             w_dig_next [DIGITS];

    // Binary field passes through untouched; each BCD nibble gets its own corrector.
    assign w_sr_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit(r_sr[WIDTH+4*g +: 4]),
            .o_digit(w_sr_adj[WIDTH+4*g +: 4])
        );
    end

    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend;
        w_done_next  = 1'b0;
        w_ovf_next   = r_ovf;
        w_dig_next   = r_dig;
        unique case (r_state)
            IDLE: begin
                if (bus_if.start) begin
                    w_sr_next    = {{BCD_W{1'b0}}, bus_if.bin_in};
                    w_pend_next  = 32'(bus_if.bin_in) > MAX_VALUE;
                    w_cnt_next   = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_sr_next  = {w_sr_adj[SR_W-2:0], 1'b0};
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                for (int i = 0; i < DIGITS; i++) begin
                    w_dig_next[i] = r_pend ? 4'd9 : r_sr[WIDTH+4*i +: 4];
                end
                w_ovf_next   = r_pend;
                w_done_next  = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_dig[i] <= 4'd0;
            end
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            r_cnt   <= w_cnt_next;
            r_pend  <= w_pend_next;
            r_done  <= w_done_next;
            r_ovf   <= w_ovf_next;
            r_dig   <= w_dig_next;
        end
    end

    assign bus_if.busy             = (r_state != IDLE);
    assign bus_if.done             = r_done;
    assign bus_if.overflow         = r_ovf;
    assign bus_if.unidades_output  = r_dig[0];
    assign bus_if.decenas_output   = r_dig[1];
    assign bus_if.centenas_output  = r_dig[2];
    assign bus_if.milesimas_output = r_dig[3];

endmodule

// File: tb/tb_module_bin2bcd.sv
// Randomised bench for module_bin2bcd against an arithmetic decimal-digit model.
module tb_module_bin2bcd;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bin2bcd_if bif ();

    module_bin2bcd u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: saturate, then split into decimal digits {thousands,hundreds,tens,ones}.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        logic [15:0] r;
        s = (v > 9999) ? 9999 : v;
        r[15:12] = 4'((s / 1000) % 10);
        r[11:8]  = 4'((s / 100) % 10);
        r[7:4]   = 4'((s / 10) % 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_digits();
        return {bif.milesimas_output, bif.centenas_output,
                bif.decenas_output, bif.unidades_output};
    endfunction

    task automatic check_result(input string tag, input int v);
        logic [15:0] e;
        e = ref_bcd(v);
        check({tag, "_digits"}, int'(dut_digits()), int'(e));
        check({tag, "_ovf"}, int'(bif.overflow), (v > 9999) ? 1 : 0);
    endtask

    // Launch one conversion; optionally pulse start (bin_in=42) so it is sampled at edge inject_at.
    task automatic run_conv(input string tag, input int v, input int inject_at);
        int lat;
        logic [15:0] held;
        logic [13:0] b;
        b = 14'(v);
        bif.start  = 1'b1;
        bif.bin_in = b;
        @(posedge clk); #1;
        bif.start  = 1'b0;
        bif.bin_in = 14'($urandom);
        check({tag, "_busy_e0"}, int'(bif.busy), 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == inject_at) begin
                bif.start  = 1'b1;
                bif.bin_in = 14'd42;
            end
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (bif.done) begin
                lat = k;
                break;
            end
            if (!bif.busy) begin
                check({tag, "_busy_during"}, int'(bif.busy), 1);
            end
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, lat, 15);
            check({tag, "_busy_at_done"}, int'(bif.busy), 0);
            check_result(tag, v);
            held = dut_digits();
            @(posedge clk); #1;
            check({tag, "_done_single"}, int'(bif.done), 0);
            check({tag, "_hold"}, int'(dut_digits()), int'(held));
        end
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        n_checks   = 0;
        n_errors   = 0;
        bif.start  = 1'b0;
        bif.bin_in = '0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_digits", int'(dut_digits()), 0);
        check("rst_ovf", int'(bif.overflow), 0);
        check("rst_busy", int'(bif.busy), 0);
        check("rst_done", int'(bif.done), 0);

        run_conv("zero", 0, 0);
        run_conv("v1234", 1234, 0);
        run_conv("v9999", 9999, 0);
        run_conv("v10000", 10000, 0);
        run_conv("v16383", 16383, 0);
        run_conv("ignore", 5678, 5);
        run_conv("after_ovf", 7, 0);

        // Abort a conversion with an asynchronous reset mid-flight.
        bif.start  = 1'b1;
        bif.bin_in = 14'd4321;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_digits", int'(dut_digits()), 0);
        check("abort_busy", int'(bif.busy), 0);
        check("abort_ovf", int'(bif.overflow), 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bif.done) check("abort_no_done", int'(bif.done), 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bif.done) check("abort_no_done_rel", int'(bif.done), 0);
        end
        run_conv("v87", 87, 0);

        // Back-to-back with start held high; bin_in changes after acceptance.
        bif.start  = 1'b1;
        bif.bin_in = 14'd100;
        @(posedge clk); #1;
        bif.bin_in = 14'd250;
        t1 = 0;
        t2 = 0;
        cyc = 0;
        for (int k = 1; k <= 60 && t2 == 0; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (k == 17) bif.start = 1'b0;
            if (bif.done) begin
                if (t1 == 0) begin
                    t1 = k;
                    check_result("b2b_first", 100);
                end else begin
                    t2 = k;
                    check_result("b2b_second", 250);
                end
            end else if (t1 != 0 && dut_digits() != ref_bcd(100)) begin
                check("b2b_stable", int'(dut_digits()), int'(ref_bcd(100)));
            end
        end
        bif.start = 1'b0;
        check("b2b_first_lat", t1, 15);
        check("b2b_spacing", t2 - t1, 16);
        if (cyc == 0) check("b2b_ran", cyc, 1);

        for (int n = 0; n < 30; n++) begin
            int v;
            v = (n % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
            run_conv("rand", v, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
